light_zone_scheduler: RTL and testbench

Multi-zone occupancy lighting controller for the smart store. Each zone has a PIR sensor. The block keeps a zone lit while it is occupied and for a fixed hold time after occupancy ends. It also caps the number of simultaneously lit zones at a power budget, granting waiting zones round-robin. It sits between the raw PIR inputs and the zone light drivers, and replaces per-zone edge-triggered light latches with a single clocked scheduler.

---
 rtl/light_zone_scheduler.sv | 166 ++++++++++++++++
 tb/tb_light_zone_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/light_zone_scheduler.sv
// Multi-zone occupancy lighting scheduler: per-zone OFF/REQ/ON/HOLD FSMs with
// hold timers, and a round-robin arbiter that caps lit zones at MAX_ON.
module light_zone_scheduler #(
    parameter int ZONES       = 4,
    parameter int MAX_ON      = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ZONES-1:0]           pir,
    output logic [ZONES-1:0]           light,
    output logic [ZONES-1:0]           waiting,
    output logic [$clog2(ZONES+1)-1:0] on_count
);
    localparam int CNT_W  = $clog2(ZONES + 1);
    localparam int PTR_W  = $clog2(ZONES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [CNT_W-1:0]  MAX_ON_C  = CNT_W'(MAX_ON);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_REQ  = 2'd1,
        S_ON   = 2'd2,
        S_HOLD = 2'd3
    } zone_state_t;

    logic [ZONES-1:0]  r_pir_meta;
    logic [ZONES-1:0]  r_pir_s;
    zone_state_t       r_state     [ZONES];
    zone_state_t       w_state_nxt [ZONES];
    logic [HOLD_W-1:0] r_hold_cnt  [ZONES];
    logic [HOLD_W-1:0] w_hold_nxt  [ZONES];
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_rr_nxt;
    logic [CNT_W-1:0]  r_on_count;
    logic [CNT_W-1:0]  w_on_count_nxt;
    logic [ZONES-1:0]  w_eligible;
    logic              w_grant_vld;
    logic [PTR_W-1:0]  w_grant_idx;

    // Zone index 'off' places after 'base', wrapping modulo ZONES.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= ZONES) ? (sum - ZONES) : sum;
        return sum[PTR_W-1:0];
    endfunction

    // Eligibility: waiting zone still occupied while a budget slot is free.
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            w_eligible[i] = enable && (r_on_count < MAX_ON_C) &&
                            (r_state[i] == S_REQ) && r_pir_s[i];
        end
    end

    // Round-robin pick: scanning from the far end leaves the zone closest to rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = {PTR_W{1'b0}};
        for (int k = ZONES - 1; k >= 0; k--) begin
            w_grant_vld = w_grant_vld | w_eligible[wrap_idx(r_rr_ptr, k)];
            w_grant_idx = w_eligible[wrap_idx(r_rr_ptr, k)] ? wrap_idx(r_rr_ptr, k) : w_grant_idx;
        end
        w_rr_nxt = w_grant_vld ? wrap_idx(w_grant_idx, 1) : r_rr_ptr;
    end

    // Per-zone next state, hold timers and next-state lit count.
    always_comb begin
        w_on_count_nxt = {CNT_W{1'b0}};
        for (int i = 0; i < ZONES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hold_nxt[i]  = r_hold_cnt[i];
            if (!enable) begin
                w_state_nxt[i] = S_OFF;
                w_hold_nxt[i]  = HOLD_ZERO;
            end else begin
                case (r_state[i])
                    S_OFF: begin
                        if (r_pir_s[i]) begin
                            w_state_nxt[i] = S_REQ;
                        end else begin
                            w_state_nxt[i] = S_OFF;
                        end
                    end
                    S_REQ: begin
                        if (!r_pir_s[i]) begin
                            w_state_nxt[i] = S_OFF;
                        end else if (w_grant_vld && (w_grant_idx == PTR_W'(i))) begin
                            w_state_nxt[i] = S_ON;
                        end else begin
                            w_state_nxt[i] = S_REQ;
                        end
                    end
                    S_ON: begin
                        if (!r_pir_s[i]) begin
                            w_state_nxt[i] = S_HOLD;
                            w_hold_nxt[i]  = HOLD_LOAD;
                        end else begin
                            w_state_nxt[i] = S_ON;
                        end
                    end
                    S_HOLD: begin
                        // Re-occupancy keeps its slot, so no arbitration is needed.
                        if (r_pir_s[i]) begin
                            w_state_nxt[i] = S_ON;
                            w_hold_nxt[i]  = HOLD_ZERO;
                        end else if (r_hold_cnt[i] == HOLD_ZERO) begin
                            w_state_nxt[i] = S_OFF;
                        end else begin
                            w_hold_nxt[i] = r_hold_cnt[i] - HOLD_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = S_OFF;
                        w_hold_nxt[i]  = HOLD_ZERO;
                    end
                endcase
            end
            if ((w_state_nxt[i] == S_ON) || (w_state_nxt[i] == S_HOLD)) begin
                w_on_count_nxt = w_on_count_nxt + CNT_ONE;
            end else begin
                w_on_count_nxt = w_on_count_nxt;
            end
        end
    end

    // State registers: PIR synchronizers, zone FSMs, hold timers, arbiter pointer, lit count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pir_meta <= {ZONES{1'b0}};
            r_pir_s    <= {ZONES{1'b0}};
            r_rr_ptr   <= {PTR_W{1'b0}};
            r_on_count <= {CNT_W{1'b0}};
            for (int i = 0; i < ZONES; i++) begin
                r_state[i]    <= S_OFF;
                r_hold_cnt[i] <= HOLD_ZERO;
            end
        end else begin
            r_pir_meta <= pir;
            r_pir_s    <= r_pir_meta;
            r_rr_ptr   <= w_rr_nxt;
            r_on_count <= w_on_count_nxt;
            for (int i = 0; i < ZONES; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_hold_cnt[i] <= w_hold_nxt[i];
            end
        end
    end

    // Output decode straight from the zone state registers.
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            light[i]   = (r_state[i] == S_ON) || (r_state[i] == S_HOLD);
            waiting[i] = (r_state[i] == S_REQ);
        end
        on_count = r_on_count;
    end

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Directed bench for light_zone_scheduler (ZONES=4, MAX_ON=2, HOLD_CYCLES=8)
// with hand-computed expectations for latency, budget cap, round-robin and hold.
module tb_light_zone_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] pir;
    logic [3:0] light;
    logic [3:0] waiting;
    logic [2:0] on_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    light_zone_scheduler #(
        .ZONES       (4),
        .MAX_ON      (2),
        .HOLD_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pir      (pir),
        .light    (light),
        .waiting  (waiting),
        .on_count (on_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        pir    = 4'b0000;
        #2;
        check_eq("rst_light",   32'(light),        32'h0);
        check_eq("rst_waiting", 32'(waiting),      32'h0);
        check_eq("rst_count",   32'(on_count),     32'h0);
        check_eq("rst_rr",      32'(dut.r_rr_ptr), 32'h0);
        step(1);
        reset = 1'b0;

        // Single zone: light 3 clocks after rise, off 2+8 after fall.
        pir = 4'b0001;
        step(3);
        check_eq("s1_req_wait",  32'(waiting),  32'h1);
        check_eq("s1_req_light", 32'(light),    32'h0);
        step(1);
        check_eq("s1_on_light",  32'(light),    32'h1);
        check_eq("s1_on_count",  32'(on_count), 32'h1);
        step(6);
        pir = 4'b0000;
        step(10);
        check_eq("s1_hold_light", 32'(light),    32'h1);
        check_eq("s1_hold_count", 32'(on_count), 32'h1);
        step(1);
        check_eq("s1_off_light", 32'(light),    32'h0);
        check_eq("s1_off_count", 32'(on_count), 32'h0);

        // Budget cap: one grant per cycle, two zones max.
        reset_pulse();
        pir = 4'b1111;
        step(3);
        check_eq("s2_all_wait", 32'(waiting), 32'hf);
        check_eq("s2_no_light", 32'(light),   32'h0);
        step(1);
        check_eq("s2_g0_light", 32'(light),    32'h1);
        check_eq("s2_g0_wait",  32'(waiting),  32'he);
        check_eq("s2_g0_count", 32'(on_count), 32'h1);
        step(1);
        check_eq("s2_g1_light", 32'(light),    32'h3);
        check_eq("s2_g1_wait",  32'(waiting),  32'hc);
        check_eq("s2_g1_count", 32'(on_count), 32'h2);
        step(1);
        check_eq("s2_cap_light", 32'(light),        32'h3);
        check_eq("s2_cap_count", 32'(on_count),     32'h2);
        check_eq("s2_rr",        32'(dut.r_rr_ptr), 32'h2);

        // Round-robin release: zone 2 wins the freed slot, not zone 3.
        pir = 4'b1110;
        step(10);
        check_eq("s3_hold_light", 32'(light), 32'h3);
        step(1);
        check_eq("s3_off_light", 32'(light),    32'h2);
        check_eq("s3_off_count", 32'(on_count), 32'h1);
        check_eq("s3_off_wait",  32'(waiting),  32'hc);
        step(1);
        check_eq("s3_g2_light", 32'(light),        32'h6);
        check_eq("s3_g2_wait",  32'(waiting),      32'h8);
        check_eq("s3_g2_count", 32'(on_count),     32'h2);
        check_eq("s3_rr",       32'(dut.r_rr_ptr), 32'h3);

        // Re-trigger in hold: zone 1 stays lit and never re-requests.
        pir = 4'b1100;
        for (int c = 0; c < 11; c++) begin
            step(1);
            check_eq("s4_light1", 32'(light[1]),   32'h1);
            check_eq("s4_wait1",  32'(waiting[1]), 32'h0);
            if (c == 4) begin
                check_eq("s4_in_hold", 32'(dut.r_state[1]), 32'h3);
            end
            if (c == 5) begin
                pir[1] = 1'b1;
            end
        end
        check_eq("s4_back_on", 32'(dut.r_state[1]), 32'h2);
        check_eq("s4_wait",    32'(waiting),        32'h8);

        // Withdraw while waiting: zone 3 leaves REQ without ever lighting.
        pir = 4'b0110;
        step(2);
        check_eq("s5_still_wait", 32'(waiting), 32'h8);
        step(1);
        check_eq("s5_wait",  32'(waiting),  32'h0);
        check_eq("s5_light", 32'(light),    32'h6);
        check_eq("s5_count", 32'(on_count), 32'h2);

        // Enable drop clears lit zones after one edge.
        enable = 1'b0;
        step(1);
        check_eq("s6_en_light", 32'(light),    32'h0);
        check_eq("s6_en_count", 32'(on_count), 32'h0);
        check_eq("s6_en_wait",  32'(waiting),  32'h0);
        pir = 4'b0010;
        step(3);
        enable = 1'b1;
        step(2);
        check_eq("s6_relit", 32'(light), 32'h2);
        pir = 4'b0000;
        step(5);
        check_eq("s6_mid_hold", 32'(dut.r_state[1]), 32'h3);
        check_eq("s6_hold_light", 32'(light), 32'h2);

        // Reset mid-hold drops outputs without a clock edge.
        reset = 1'b1;
        #1;
        check_eq("s6_rst_light", 32'(light),    32'h0);
        check_eq("s6_rst_wait",  32'(waiting),  32'h0);
        check_eq("s6_rst_count", 32'(on_count), 32'h0);
        pir = 4'b0010;
        #1;
        reset = 1'b0;
        step(3);
        check_eq("s6_post_wait",  32'(waiting), 32'h2);
        check_eq("s6_post_dark",  32'(light),   32'h0);
        step(1);
        check_eq("s6_post_light", 32'(light),    32'h2);
        check_eq("s6_post_count", 32'(on_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
